// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles.
// Define IDEX_PERF_EN to add bubble/flush performance counters.
module id_ex_stage #(
    parameter int REGW  = 5,
    parameter int DATAW = 32
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef IDEX_PERF_EN
    input  logic             perf_clr,
    output logic [31:0]      perf_bubbles,
    output logic [31:0]      perf_flushes,
`endif
    input  logic             id_valid,
    input  logic [3:0]       id_aluop,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_dest,
    input  logic             id_uses_rt,
    input  logic [DATAW-1:0] id_rsdat,
    input  logic [DATAW-1:0] id_rtdat,
    input  logic [DATAW-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic             id_alusrc,
    input  logic             id_shift,
    input  logic             id_regwr,
    input  logic             id_memrd,
    input  logic             id_memwr,
    input  logic             ex_stall,
    input  logic             flush,
    input  logic             exm_wen,
    input  logic [REGW-1:0]  exm_reg,
    input  logic [DATAW-1:0] exm_dat,
    input  logic             mwb_wen,
    input  logic [REGW-1:0]  mwb_reg,
    input  logic [DATAW-1:0] mwb_dat,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [DATAW-1:0] alu_in1,
    output logic [DATAW-1:0] alu_in2,
    output logic [3:0]       aluop,
    output logic [DATAW-1:0] ex_store_data,
    output logic [REGW-1:0]  ex_dest,
    output logic             ex_regwr,
    output logic             ex_memrd,
    output logic             ex_memwr
);

    typedef struct packed {
        logic             v;
        logic [3:0]       aluop;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  dest;
        logic [DATAW-1:0] rsdat;
        logic [DATAW-1:0] rtdat;
        logic [DATAW-1:0] imm;
        logic [4:0]       shamt;
        logic             alusrc;
        logic             shift;
        logic             regwr;
        logic             memrd;
        logic             memwr;
    } stage_t;

    stage_t stage_q, stage_d;

    logic [DATAW-1:0] fwd_rs, fwd_rt;
    logic [DATAW-1:0] ld_rsdat, ld_rtdat;
    logic             luh;

    always_comb begin
        fwd_rs = stage_q.rsdat;
        if (exm_wen && exm_reg == stage_q.rs && stage_q.rs != '0)
            fwd_rs = exm_dat;
        else if (mwb_wen && mwb_reg == stage_q.rs && stage_q.rs != '0)
            fwd_rs = mwb_dat;

        fwd_rt = stage_q.rtdat;
        if (exm_wen && exm_reg == stage_q.rt && stage_q.rt != '0)
            fwd_rt = exm_dat;
        else if (mwb_wen && mwb_reg == stage_q.rt && stage_q.rt != '0)
            fwd_rt = mwb_dat;
    end

    // Register file is written on the same edge we capture, so bypass MEM/WB here.
    assign ld_rsdat = (mwb_wen && mwb_reg == id_rs && id_rs != '0) ? mwb_dat : id_rsdat;
    assign ld_rtdat = (mwb_wen && mwb_reg == id_rt && id_rt != '0) ? mwb_dat : id_rtdat;

    assign luh = stage_q.v && stage_q.memrd && stage_q.dest != '0 && id_valid &&
                 (id_rs == stage_q.dest || (id_uses_rt && id_rt == stage_q.dest));

    assign id_stall = ~RST & (ex_stall | (luh & ~flush));

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.v = 1'b0;
        end else if (ex_stall) begin
            stage_d.rsdat = fwd_rs;
            stage_d.rtdat = fwd_rt;
        end else if (luh) begin
            stage_d.v = 1'b0;
        end else begin
            stage_d.v      = id_valid;
            stage_d.aluop  = id_aluop;
            stage_d.rs     = id_rs;
            stage_d.rt     = id_rt;
            stage_d.dest   = id_dest;
            stage_d.rsdat  = ld_rsdat;
            stage_d.rtdat  = ld_rtdat;
            stage_d.imm    = id_imm;
            stage_d.shamt  = id_shamt;
            stage_d.alusrc = id_alusrc;
            stage_d.shift  = id_shift;
            stage_d.regwr  = id_regwr;
            stage_d.memrd  = id_memrd;
            stage_d.memwr  = id_memwr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    always_comb begin
        ex_valid      = stage_q.v;
        ex_dest       = stage_q.dest;
        alu_in1       = '0;
        alu_in2       = '0;
        aluop         = '0;
        ex_store_data = '0;
        ex_regwr      = 1'b0;
        ex_memrd      = 1'b0;
        ex_memwr      = 1'b0;
        if (stage_q.v) begin
            if (stage_q.shift) begin
                alu_in1 = fwd_rt;
                alu_in2 = {{(DATAW-5){1'b0}}, stage_q.shamt};
            end else begin
                alu_in1 = fwd_rs;
                alu_in2 = stage_q.alusrc ? stage_q.imm : fwd_rt;
            end
            aluop         = stage_q.aluop;
            ex_store_data = fwd_rt;
            ex_regwr      = stage_q.regwr;
            ex_memrd      = stage_q.memrd;
            ex_memwr      = stage_q.memwr;
        end
    end

`ifdef IDEX_PERF_EN
    logic [31:0] perf_bubbles_q, perf_flushes_q;

    always_ff @(posedge CLK) begin
        if (RST || perf_clr) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (luh && !flush && !ex_stall)
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            if (flush && stage_q.v)
                perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushes = perf_flushes_q;
`else
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a reference model.
module tb_id_ex_stage;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SLL = 4'h5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [3:0]  id_aluop;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rt;
    logic [31:0] id_rsdat, id_rtdat, id_imm;
    logic [4:0]  id_shamt;
    logic        id_alusrc, id_shift, id_regwr, id_memrd, id_memwr;
    logic        ex_stall, flush;
    logic        exm_wen;
    logic [4:0]  exm_reg;
    logic [31:0] exm_dat;
    logic        mwb_wen;
    logic [4:0]  mwb_reg;
    logic [31:0] mwb_dat;
    logic        id_stall, ex_valid;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  aluop;
    logic [4:0]  ex_dest;
    logic        ex_regwr, ex_memrd, ex_memwr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.REGW(5), .DATAW(32)) dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_uses_rt(id_uses_rt),
        .id_rsdat(id_rsdat), .id_rtdat(id_rtdat), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc(id_alusrc), .id_shift(id_shift),
        .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
        .ex_stall(ex_stall), .flush(flush),
        .exm_wen(exm_wen), .exm_reg(exm_reg), .exm_dat(exm_dat),
        .mwb_wen(mwb_wen), .mwb_reg(mwb_reg), .mwb_dat(mwb_dat),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .aluop(aluop),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr)
    );

    // Reference: the instruction currently held by the stage.
    logic        m_v;
    logic [3:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_dest, m_sh;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic        m_src, m_shf, m_wr, m_rd, m_mw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
        if (r == 5'd0) return stored;
        if (exm_wen && exm_reg == r) return exm_dat;
        if (mwb_wen && mwb_reg == r) return mwb_dat;
        return stored;
    endfunction

    function automatic logic model_luh();
        return m_v && m_rd && m_dest != 5'd0 && id_valid &&
               (id_rs == m_dest || (id_uses_rt && id_rt == m_dest));
    endfunction

    task automatic model_reset();
        {m_v, m_op, m_rs, m_rt, m_dest, m_sh} = '0;
        {m_rsd, m_rtd, m_imm} = '0;
        {m_src, m_shf, m_wr, m_rd, m_mw} = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] fr, ft, a1, a2;
        logic        stall_exp;
        fr = fwd(m_rs, m_rsd);
        ft = fwd(m_rt, m_rtd);
        stall_exp = RST ? 1'b0 : (ex_stall || (model_luh() && !flush));
        a1 = m_shf ? ft : fr;
        a2 = m_shf ? {27'd0, m_sh} : (m_src ? m_imm : ft);
        check("id_stall", {31'd0, id_stall}, {31'd0, stall_exp});
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_v});
        check("ex_dest",  {27'd0, ex_dest}, {27'd0, m_dest});
        check("alu_in1",  alu_in1, m_v ? a1 : 32'd0);
        check("alu_in2",  alu_in2, m_v ? a2 : 32'd0);
        check("aluop",    {28'd0, aluop}, m_v ? {28'd0, m_op} : 32'd0);
        check("store",    ex_store_data, m_v ? ft : 32'd0);
        check("ctrl",     {29'd0, ex_regwr, ex_memrd, ex_memwr},
                          m_v ? {29'd0, m_wr, m_rd, m_mw} : 32'd0);
    endtask

    task automatic model_update();
        logic [31:0] fr, ft;
        logic        luh;
        fr  = fwd(m_rs, m_rsd);
        ft  = fwd(m_rt, m_rtd);
        luh = model_luh();
        if (RST) begin
            model_reset();
        end else if (flush) begin
            m_v = 1'b0;
        end else if (ex_stall) begin
            m_rsd = fr;
            m_rtd = ft;
        end else if (luh) begin
            m_v = 1'b0;
        end else begin
            m_v = id_valid; m_op = id_aluop;
            m_rs = id_rs; m_rt = id_rt; m_dest = id_dest;
            m_rsd = (mwb_wen && mwb_reg == id_rs && id_rs != 0) ? mwb_dat : id_rsdat;
            m_rtd = (mwb_wen && mwb_reg == id_rt && id_rt != 0) ? mwb_dat : id_rtdat;
            m_imm = id_imm; m_sh = id_shamt;
            m_src = id_alusrc; m_shf = id_shift;
            m_wr = id_regwr; m_rd = id_memrd; m_mw = id_memwr;
        end
    endtask

    task automatic clear_inputs();
        RST = 1'b0; id_valid = 1'b0; id_aluop = '0;
        id_rs = '0; id_rt = '0; id_dest = '0; id_uses_rt = 1'b0;
        id_rsdat = '0; id_rtdat = '0; id_imm = '0; id_shamt = '0;
        id_alusrc = 1'b0; id_shift = 1'b0;
        id_regwr = 1'b0; id_memrd = 1'b0; id_memwr = 1'b0;
        ex_stall = 1'b0; flush = 1'b0;
        exm_wen = 1'b0; exm_reg = '0; exm_dat = '0;
        mwb_wen = 1'b0; mwb_reg = '0; mwb_dat = '0;
    endtask

    // Inputs are driven 1 time unit after a rising edge; check, then clock.
    task automatic step();
        #1;
        check_outputs();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_add(input logic [4:0] rs, input logic [31:0] rsd,
                            input logic [4:0] rt, input logic [31:0] rtd);
        id_valid = 1'b1; id_aluop = ALU_ADD; id_regwr = 1'b1; id_dest = 5'd10;
        id_rs = rs; id_rsdat = rsd; id_rt = rt; id_rtdat = rtd; id_uses_rt = 1'b1;
    endtask

    task automatic load_lw8();
        clear_inputs();
        id_valid = 1'b1; id_aluop = ALU_ADD; id_memrd = 1'b1; id_regwr = 1'b1;
        id_dest = 5'd8; id_rs = 5'd1; id_alusrc = 1'b1; id_imm = 32'd4;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        ex_stall = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        model_reset();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_stall", {31'd0, id_stall}, 32'd0);
        check("rst_in1", alu_in1, 32'd0);
        check("rst_ctrl", {29'd0, ex_regwr, ex_memrd, ex_memwr}, 32'd0);

        // Plain ADD
        clear_inputs();
        load_add(5'd3, 32'd5, 5'd4, 32'd7);
        step();
        clear_inputs();
        #1;
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_in1", alu_in1, 32'd5);
        check("add_in2", alu_in2, 32'd7);
        check("add_op", {28'd0, aluop}, {28'd0, ALU_ADD});

        // Forwarding priority on rs=3
        exm_wen = 1'b1; exm_reg = 5'd3; exm_dat = 32'h11;
        mwb_wen = 1'b1; mwb_reg = 5'd3; mwb_dat = 32'h22;
        #1 check("fwd_exm", alu_in1, 32'h11);
        exm_wen = 1'b0;
        #1 check("fwd_mwb", alu_in1, 32'h22);
        clear_inputs();
        load_add(5'd0, 32'h55, 5'd4, 32'd7);
        mwb_wen = 1'b1; mwb_reg = 5'd0; mwb_dat = 32'h22;
        step();
        exm_wen = 1'b1; exm_reg = 5'd0; exm_dat = 32'h11;
        #1 check("fwd_r0", alu_in1, 32'h55);

        // Load-use bubble
        load_lw8();
        step();
        clear_inputs();
        load_add(5'd8, 32'd0, 5'd2, 32'd0);
        #1 check("luh_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("luh_bubble", {31'd0, ex_valid}, 32'd0);
        check("luh_release", {31'd0, id_stall}, 32'd0);
        step();
        check("luh_load", {31'd0, ex_valid}, 32'd1);

        // Operand refresh during a stall
        clear_inputs();
        load_add(5'd1, 32'd0, 5'd9, 32'd0);
        step();
        clear_inputs();
        ex_stall = 1'b1;
        mwb_wen = 1'b1; mwb_reg = 5'd9; mwb_dat = 32'hAB;
        step();
        mwb_wen = 1'b0;
        step();
        step();
        ex_stall = 1'b0;
        #1 check("stall_keep", alu_in2, 32'hAB);

        // Flush beats stall and load-use
        load_lw8();
        step();
        clear_inputs();
        load_add(5'd8, 32'd0, 5'd2, 32'd0);
        ex_stall = 1'b1; flush = 1'b1;
        #1 check("flush_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_ctrl", {29'd0, ex_regwr, ex_memrd, ex_memwr}, 32'd0);

        // Shift and immediate operand selection
        clear_inputs();
        id_valid = 1'b1; id_aluop = ALU_SLL; id_shift = 1'b1; id_shamt = 5'd4;
        id_rt = 5'd2; id_rtdat = 32'd1; id_rs = 5'd5; id_rsdat = 32'h99; id_uses_rt = 1'b1;
        step();
        clear_inputs();
        #1;
        check("sll_in1", alu_in1, 32'd1);
        check("sll_in2", alu_in2, 32'd4);
        id_valid = 1'b1; id_alusrc = 1'b1; id_imm = 32'hFFFF_FFF0; id_rs = 5'd6;
        step();
        clear_inputs();
        #1 check("imm_in2", alu_in2, 32'hFFFF_FFF0);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 99) < 8);
            ex_stall   = ($urandom_range(0, 99) < 20);
            id_valid   = ($urandom_range(0, 99) < 80);
            id_aluop   = 4'($urandom);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            id_dest    = 5'($urandom_range(0, 7));
            id_uses_rt = 1'($urandom);
            id_rsdat   = $urandom;
            id_rtdat   = $urandom;
            id_imm     = $urandom;
            id_shamt   = 5'($urandom);
            id_alusrc  = 1'($urandom);
            id_shift   = ($urandom_range(0, 3) == 0);
            id_regwr   = 1'($urandom);
            id_memrd   = ($urandom_range(0, 99) < 30);
            id_memwr   = 1'($urandom);
            exm_wen    = 1'($urandom);
            exm_reg    = 5'($urandom_range(0, 7));
            exm_dat    = $urandom;
            mwb_wen    = 1'($urandom);
            mwb_reg    = 5'($urandom_range(0, 7));
            mwb_dat    = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for each core's execute stage; feeds operands and opcode directly into the ALU.
- Latches decoded instructions and control.
- Resolves EX/MEM and MEM/WB forwarding on the registered operands.
- Detects load-use hazards and injects bubbles.
- Honours downstream stall and branch/jump flush.

Parameters:
REGW, 5, register index width
DATAW, 32, data / operand width

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  synchronous active-high reset
id_valid  in  1  decode holds a real instruction
id_aluop  in  4  aluop_t from decode
id_rs, id_rt, id_dest  in  REGW  source A, source B, destination indices
id_uses_rt  in  1  instruction reads rt
id_rsdat, id_rtdat  in  DATAW  register file read data
id_imm  in  DATAW  already-extended immediate
id_shamt  in  5  shift amount
id_alusrc  in  1  1: operand B = immediate
id_shift  in  1  1: operand A = rt, B = shamt
id_regwr, id_memrd, id_memwr  in  1 each  control
ex_stall  in  1  downstream cannot accept; hold
flush  in  1  squash register content
exm_wen  in  1  EX/MEM result will write a register
exm_reg  in  REGW  EX/MEM destination
exm_dat  in  DATAW  EX/MEM result
mwb_wen  in  1  MEM/WB writeback enable
mwb_reg  in  REGW  MEM/WB destination
mwb_dat  in  DATAW  MEM/WB writeback data
id_stall  out  1  decode must hold
ex_valid  out  1  stage holds a real instruction
alu_in1, alu_in2  out  DATAW  ALU operands
aluop  out  4  ALU opcode
ex_store_data  out  DATAW  forwarded rt, for stores
ex_dest  out  REGW  destination
ex_regwr, ex_memrd, ex_memwr  out  1 each  control, gated by ex_valid

Behaviour:
- Reset:
  - All registered fields are 0 and ex_valid=0.
  - All outputs are 0, including id_stall.
- Update priority on each CLK edge: RST > flush > ex_stall > load-use bubble > load.
- flush:
  - Sets v=0 next cycle, even if ex_stall is high.
  - Same-cycle load-use is ignored.
- ex_stall (without flush):
  - Every field holds.
  - Operand refresh: the stored rs/rt data is overwritten with this cycle's forwarded values, so a MEM/WB value that retires during the stall is not lost.
- Load-use condition, luh: v & memrd_q & dest_q!=0 & id_valid & (id_rs==dest_q | (id_uses_rt & id_rt==dest_q)).
  - If luh and no stall/flush: the register loads a bubble (v=0) and decode holds.
- Load: all id_* fields are captured.
  - Captured id_rsdat/id_rtdat pass through a MEM/WB forward mux keyed on id_rs/id_rt (covers same-edge register file write).
- id_stall = ex_stall | (luh & ~flush). Combinational.
- Forward mux, per operand X in {rs, rt}:
  - EX/MEM wins if exm_wen & exm_reg==X_q & X_q!=0.
  - Otherwise MEM/WB if mwb_wen & mwb_reg==X_q & X_q!=0.
  - Otherwise the stored data.
  - Register 0 is never forwarded.
- Operand select:
  - shift_q=1: alu_in1 = fwd_rt, alu_in2 = zero-extended shamt_q.
  - else: alu_in1 = fwd_rs; alu_in2 = alusrc_q ? imm_q : fwd_rt.
  - ex_store_data = fwd_rt.
- When ex_valid=0, all of the following are forced to 0:
  - alu_in1, alu_in2, aluop
  - ex_regwr, ex_memrd, ex_memwr
  - ex_store_data
- Latency: one cycle from decode to ALU inputs.
- RST asserted mid-stall clears state at the next edge regardless of other inputs.

Optional Feature:
- Macro IDEX_PERF_EN. When defined, add outputs:
  - perf_bubbles (32): counts luh-inserted bubbles.
  - perf_flushes (32): counts flush cycles with v=1.
  - perf_clr (1, input): synchronous clear.
- Counters reset to 0 and wrap at 2^32-1 → 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then load ADD with rs=3 (data 5), rt=4 (data 7), no forwarding → next cycle ex_valid=1, alu_in1=5, alu_in2=7, aluop=ALU_ADD.
- EX/MEM and MEM/WB both target rs=3 (exm_dat=0x11, mwb_dat=0x22) → alu_in1=0x11; with exm_wen=0 → 0x22; with rs=0 → stored data.
- LW dest=8 in stage, decode ADD rs=8 → id_stall=1 for one cycle, next ex_valid=0, then ADD loads.
- ex_stall 3 cycles while mwb forwards rt=9 (0xAB) only in the first cycle → after release, alu_in2=0xAB.
- flush together with ex_stall and luh → next ex_valid=0, all control outputs 0; with IDEX_PERF_EN, perf_flushes +1 and perf_bubbles unchanged.
- SLL shamt=4, rt=2 (data 1) → alu_in1=1, alu_in2=4; ALUSRC immediate 0xFFFFFFF0 → alu_in2=0xFFFFFFF0.
